// File: rtl/inference_sequencer.sv
// Job-level sequencer for the systolic inference datapath: loads N weight rows,
// streams the job's input rows, drains the pipeline and forwards result rows.
module inference_sequencer #(
  parameter int unsigned N            = 8,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned CNT_W        = 7,
  parameter int unsigned DRAIN_CYCLES = 24
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_start,
  input  logic [CNT_W-1:0]  cmd_num_inputs,
  input  logic [1:0]        cmd_mode,
  input  logic [DATA_W-1:0] cmd_bias,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              dp_start_weights,
  output logic              dp_start_array,
  output logic              dp_enable,
  output logic [DATA_W-1:0] dp_systolic_data,
  output logic [DATA_W-1:0] dp_bias_vec,
  output logic [1:0]        dp_activation_mode,
  input  logic              dp_activated,
  input  logic [DATA_W-1:0] dp_activations,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data
);

  localparam int unsigned W_CNT_W = $clog2(N + 1);
  localparam int unsigned D_CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, W_WAIT, W_LOAD, STREAM, DRAIN, FIN} state_t;

  state_t             state;
  logic [W_CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0]   i_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   num_inputs;
  logic [D_CNT_W-1:0] d_cnt;

  logic in_wload, in_stream, in_drain, counting;

  assign in_wload  = (state == W_LOAD);
  assign in_stream = (state == STREAM);
  assign in_drain  = (state == DRAIN);
  assign counting  = in_stream || in_drain || (state == FIN);

  // Datapath strobes qualify the row being handed over in this same cycle, so
  // they decode state/counters together with the live source handshake.
  assign dp_enable        = ((in_wload || in_stream) && src_valid) || in_drain;
  assign dp_systolic_data = (in_wload || (in_stream && src_valid)) ? src_data : '0;
  assign dp_start_weights = in_wload && (w_cnt == '0);
  assign dp_start_array   = in_stream && src_valid && (i_cnt == '0);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      src_ready          <= 1'b0;
      w_cnt              <= '0;
      i_cnt              <= '0;
      d_cnt              <= '0;
      num_inputs         <= '0;
      dp_bias_vec        <= '0;
      dp_activation_mode <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start) begin
            num_inputs         <= cmd_num_inputs;
            dp_bias_vec        <= cmd_bias;
            dp_activation_mode <= cmd_mode;
            err                <= 1'b0;
            busy               <= 1'b1;
            state              <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (src_valid) begin
            w_cnt     <= '0;
            src_ready <= 1'b1;
            state     <= W_LOAD;
          end
        end
        W_LOAD: begin
          // Weight loading cannot pause: a missing row aborts the job.
          if (!src_valid) begin
            err       <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            src_ready <= 1'b0;
            state     <= IDLE;
          end else if (w_cnt == W_CNT_W'(N - 1)) begin
            w_cnt <= '0;
            if (num_inputs == '0) begin
              src_ready <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              i_cnt <= '0;
              state <= STREAM;
            end
          end else begin
            w_cnt <= w_cnt + W_CNT_W'(1);
          end
        end
        STREAM: begin
          if (src_valid) begin
            if (i_cnt == num_inputs - CNT_W'(1)) begin
              d_cnt     <= '0;
              src_ready <= 1'b0;
              state     <= DRAIN;
            end else begin
              i_cnt <= i_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          d_cnt <= d_cnt + D_CNT_W'(1);
          if (r_cnt == num_inputs) begin
            done  <= 1'b1;
            state <= FIN;
          end else if (d_cnt == D_CNT_W'(DRAIN_CYCLES - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          src_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Result forwarding; only rows arriving after weight load count toward the job.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      r_cnt     <= '0;
    end else begin
      res_valid <= (state != IDLE) && dp_activated;
      if ((state != IDLE) && dp_activated) begin
        res_data <= dp_activations;
      end
      if ((state == IDLE) && cmd_start) begin
        r_cnt <= '0;
      end else if (counting && dp_activated && (r_cnt != num_inputs)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Randomised bench for inference_sequencer: a count-based job model predicts every
// output each cycle; directed jobs pin timing and counts with literal values.
module tb_inference_sequencer;

  localparam int N            = 8;
  localparam int DATA_W       = 64;
  localparam int CNT_W        = 7;
  localparam int DRAIN_CYCLES = 24;

  logic              clk;
  logic              n_rst;
  logic              cmd_start;
  logic [CNT_W-1:0]  cmd_num_inputs;
  logic [1:0]        cmd_mode;
  logic [DATA_W-1:0] cmd_bias;
  logic              busy, done, err;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              dp_start_weights, dp_start_array, dp_enable;
  logic [DATA_W-1:0] dp_systolic_data, dp_bias_vec;
  logic [1:0]        dp_activation_mode;
  logic              dp_activated;
  logic [DATA_W-1:0] dp_activations;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;

  inference_sequencer #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_start(cmd_start), .cmd_num_inputs(cmd_num_inputs), .cmd_mode(cmd_mode), .cmd_bias(cmd_bias),
    .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dp_start_weights(dp_start_weights), .dp_start_array(dp_start_array), .dp_enable(dp_enable),
    .dp_systolic_data(dp_systolic_data), .dp_bias_vec(dp_bias_vec), .dp_activation_mode(dp_activation_mode),
    .dp_activated(dp_activated), .dp_activations(dp_activations),
    .res_valid(res_valid), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endfunction

  // Job model: progress is tracked as row/result/drain counts, not as a state machine.
  bit          m_act, m_got_valid, m_fin, m_udone, m_err, m_res_v;
  int          m_w, m_i, m_d, m_r, m_n;
  logic [63:0] m_bias, m_res_d;
  logic [1:0]  m_mode;

  // 0 idle, 1 waiting for first weight, 2 weights, 3 inputs, 4 drain, 5 finish
  function automatic int phase();
    if (!m_act)       return 0;
    if (m_fin)        return 5;
    if (!m_got_valid) return 1;
    if (m_w < N)      return 2;
    if (m_i < m_n)    return 3;
    return 4;
  endfunction

  function automatic void model_reset();
    m_act = 0; m_got_valid = 0; m_fin = 0; m_udone = 0; m_err = 0; m_res_v = 0;
    m_w = 0; m_i = 0; m_d = 0; m_r = 0; m_n = 0;
    m_bias = '0; m_res_d = '0; m_mode = '0;
  endfunction

  function automatic void model_step();
    int ph;
    bit all_results;
    ph = phase();
    all_results = (m_r == m_n);
    m_udone = 0;
    m_res_v = (ph != 0) && dp_activated;
    if (m_res_v) m_res_d = dp_activations;
    if (ph >= 3 && dp_activated && m_r < m_n) m_r++;
    case (ph)
      0: if (cmd_start) begin
           m_act = 1; m_got_valid = 0; m_fin = 0; m_err = 0;
           m_w = 0; m_i = 0; m_d = 0; m_r = 0;
           m_n = int'(cmd_num_inputs); m_bias = cmd_bias; m_mode = cmd_mode;
         end
      1: if (src_valid) m_got_valid = 1;
      2: if (!src_valid) begin
           m_err = 1; m_udone = 1; m_act = 0;
         end else begin
           m_w++;
           if (m_w == N && m_n == 0) m_fin = 1;
         end
      3: if (src_valid) m_i++;
      4: begin
           if (all_results) m_fin = 1;
           else if (m_d == DRAIN_CYCLES - 1) begin m_err = 1; m_fin = 1; end
           m_d++;
         end
      default: begin m_act = 0; m_fin = 0; end
    endcase
  endfunction

  // Observations of DUT behaviour within the current job, pinned to literals later.
  int jc;
  int obs_sw_cyc, obs_done_cnt, obs_done_cyc, obs_res_cnt, obs_sa_cnt, obs_en_low, obs_consumed;

  // Compare process: sampled just before each rising edge.
  always @(negedge clk) begin
    int ph;
    #4;
    if (n_rst) begin
      chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
      chk("rst_err", err, 0);             chk("rst_src_ready", src_ready, 0);
      chk("rst_dp_enable", dp_enable, 0); chk("rst_start_w", dp_start_weights, 0);
      chk("rst_start_a", dp_start_array, 0);
      chk("rst_dp_data", dp_systolic_data, 0);
      chk("rst_bias", dp_bias_vec, 0);    chk("rst_mode", dp_activation_mode, 0);
      chk("rst_res_valid", res_valid, 0); chk("rst_res_data", res_data, 0);
      model_reset();
    end else begin
      ph = phase();
      chk("busy", busy, m_act);
      chk("done", done, (ph == 5) || m_udone);
      chk("err", err, m_err);
      chk("src_ready", src_ready, (ph == 2) || (ph == 3));
      chk("dp_enable", dp_enable, (((ph == 2) || (ph == 3)) && src_valid) || (ph == 4));
      chk("dp_data", dp_systolic_data, ((ph == 2) || (ph == 3 && src_valid)) ? src_data : 64'd0);
      chk("start_weights", dp_start_weights, (ph == 2) && (m_w == 0));
      chk("start_array", dp_start_array, (ph == 3) && (m_i == 0) && src_valid);
      chk("bias", dp_bias_vec, m_bias);
      chk("mode", dp_activation_mode, m_mode);
      chk("res_valid", res_valid, m_res_v);
      if (m_res_v) chk("res_data", res_data, m_res_d);
      if (dp_start_weights && obs_sw_cyc < 0) obs_sw_cyc = jc;
      if (done) begin obs_done_cnt++; obs_done_cyc = jc; end
      if (res_valid) obs_res_cnt++;
      if (dp_start_array) obs_sa_cnt++;
      if (src_ready && !dp_enable) obs_en_low++;
      if (src_ready && src_valid) obs_consumed++;
      model_step();
    end
  end

  // Stimulus knobs for the current job.
  int k_n, k_stall_p, k_drop_w, k_rst_i, k_stall_at, k_stall_left, k_busy_jc;
  bit k_act_on, k_noise, k_fin_cmd;
  logic [1:0]  k_mode;
  logic [63:0] k_bias;
  int act_q[$];
  int tick = 0;
  int last_due = 0;

  task automatic drive(input bit start);
    int ph, due;
    ph = phase();
    n_rst          = 1'b0;
    cmd_start      = 1'b0;
    cmd_num_inputs = CNT_W'($urandom);
    cmd_mode       = 2'($urandom);
    cmd_bias       = {$urandom, $urandom};
    if (start) begin
      cmd_start = 1'b1; cmd_num_inputs = CNT_W'(k_n); cmd_mode = k_mode; cmd_bias = k_bias;
    end else if (ph != 0 && ((jc == k_busy_jc) || (k_fin_cmd && ph == 5) || (k_noise && $urandom_range(0, 9) == 0))) begin
      cmd_start = 1'b1;
    end
    src_data  = {$urandom, $urandom};
    src_valid = 1'($urandom);
    if (ph == 1) src_valid = (k_stall_p == 0) || ($urandom_range(0, 3) != 0);
    if (ph == 2) src_valid = (m_w != k_drop_w);
    if (ph == 3) begin
      if (m_i == k_stall_at && k_stall_left > 0) begin
        src_valid = 1'b0; k_stall_left--;
      end else begin
        src_valid = ($urandom_range(0, 99) >= k_stall_p);
      end
      if (k_rst_i >= 0 && m_i == k_rst_i) begin n_rst = 1'b1; k_rst_i = -1; end
    end
    dp_activations = {$urandom, $urandom};
    dp_activated   = 1'b0;
    // Datapath stand-in: each consumed input row yields one result a few cycles later.
    if (k_act_on && ph == 3 && src_valid && !n_rst) begin
      due = tick + $urandom_range(2, 6);
      if (due <= last_due) due = last_due + 1;
      act_q.push_back(due);
      last_due = due;
    end
    if (act_q.size() > 0 && act_q[0] == tick) begin
      dp_activated = 1'b1;
      void'(act_q.pop_front());
    end else if (k_noise && ph <= 2 && $urandom_range(0, 4) == 0) begin
      dp_activated = 1'b1;
    end
    tick++;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      jc = -1000;
      drive(1'b0);
    end
  endtask

  task automatic run_job(input int n, input logic [1:0] mode, input logic [63:0] bias,
                         input int stall_p, input int drop_w, input bit act_on, input bit noise,
                         input int rst_i, input int stall_at, input int busy_jc, input bit fin_cmd);
    bit ended;
    k_n = n; k_mode = mode; k_bias = bias; k_stall_p = stall_p; k_drop_w = drop_w;
    k_act_on = act_on; k_noise = noise; k_rst_i = rst_i; k_stall_at = stall_at;
    k_stall_left = (stall_at >= 0) ? 3 : 0; k_busy_jc = busy_jc; k_fin_cmd = fin_cmd;
    act_q.delete();
    obs_sw_cyc = -1; obs_done_cnt = 0; obs_done_cyc = -1; obs_res_cnt = 0;
    obs_sa_cnt = 0; obs_en_low = 0; obs_consumed = 0;
    @(negedge clk);
    jc = 0;
    drive(1'b1);
    ended = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      jc++;
      drive(1'b0);
      if (!m_act) begin ended = 1; break; end
    end
    if (!ended) chk("job_end_within_budget", 0, 1);
    idle(2);
  endtask

  initial begin
    n_rst = 1'b1; cmd_start = 1'b0; cmd_num_inputs = '0; cmd_mode = '0; cmd_bias = '0;
    src_valid = 1'b0; src_data = '0; dp_activated = 1'b0; dp_activations = '0;
    jc = -1000; k_noise = 0; k_act_on = 0; k_stall_p = 0; k_drop_w = -1; k_rst_i = -1;
    k_stall_at = -1; k_stall_left = 0; k_busy_jc = -1; k_fin_cmd = 0;
    obs_sw_cyc = -1; obs_done_cnt = 0; obs_done_cyc = -1; obs_res_cnt = 0;
    obs_sa_cnt = 0; obs_en_low = 0; obs_consumed = 0;
    model_reset();
    repeat (3) @(negedge clk);
    idle(2);

    // Nominal job
    run_job(8, 2'd1, 64'h0101010101010101, 0, -1, 1, 0, -1, -1, -1, 0);
    chk("nom_start_weights_cycle", obs_sw_cyc, 2);
    chk("nom_done_pulses", obs_done_cnt, 1);
    chk("nom_results", obs_res_cnt, 8);
    chk("nom_start_array_pulses", obs_sa_cnt, 1);
    chk("nom_rows_consumed", obs_consumed, 16);
    chk("nom_err", err, 0);
    chk("nom_busy_after", busy, 0);

    // Three-cycle source stall between input rows 1 and 2
    run_job(4, 2'd2, 64'h1122334455667788, 0, -1, 1, 0, -1, 2, -1, 0);
    chk("stall_enable_low_cycles", obs_en_low, 3);
    chk("stall_results", obs_res_cnt, 4);
    chk("stall_err", err, 0);

    // Weight underrun at w = 5
    run_job(6, 2'd0, 64'hdeadbeefcafef00d, 0, 5, 1, 0, -1, -1, -1, 0);
    chk("underrun_err", err, 1);
    chk("underrun_done_pulses", obs_done_cnt, 1);
    chk("underrun_start_array", obs_sa_cnt, 0);
    chk("underrun_rows_consumed", obs_consumed, 5);

    // Zero input rows
    run_job(0, 2'd1, 64'h0f0f0f0f0f0f0f0f, 0, -1, 1, 0, -1, -1, -1, 0);
    chk("zero_done_cycle", obs_done_cyc, 10);
    chk("zero_rows_consumed", obs_consumed, 8);
    chk("zero_results", obs_res_cnt, 0);
    chk("zero_err", err, 0);

    // Drain timeout with no results
    run_job(2, 2'd3, 64'h00000000ffffffff, 0, -1, 0, 0, -1, -1, -1, 0);
    chk("timeout_done_cycle", obs_done_cyc, 36);
    chk("timeout_err", err, 1);
    chk("timeout_results", obs_res_cnt, 0);

    // cmd_start during W_LOAD and during FIN are both ignored
    run_job(3, 2'd3, 64'ha5a5a5a5a5a5a5a5, 0, -1, 1, 0, -1, -1, 5, 1);
    chk("busy_cmd_bias_kept", dp_bias_vec, 64'ha5a5a5a5a5a5a5a5);
    chk("busy_cmd_mode_kept", dp_activation_mode, 3);
    chk("busy_cmd_done_pulses", obs_done_cnt, 1);
    chk("fin_cmd_not_accepted", busy, 0);

    // Reset while streaming input row 3
    run_job(8, 2'd1, 64'h0123456789abcdef, 0, -1, 1, 0, 3, -1, -1, 0);
    chk("midrst_done_pulses", obs_done_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_bias_cleared", dp_bias_vec, 0);

    // Randomised jobs
    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(0, 12), 2'($urandom), {$urandom, $urandom}, $urandom_range(0, 40),
              ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : -1,
              ($urandom_range(0, 4) != 0), 1, -1, -1, -1, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
Command-level controller for the systolic inference datapath (8x8 array with staggering FIFOs, bias adder and activation stage). It accepts one job per command: weight matrix, input row count, bias vector and activation mode. It pulls weight rows and then input rows from a ready/valid source and drives the datapath strobes (start_weights, start_array, enable). It then drains the pipeline and forwards each activated result row with a valid strobe.

Parameters:
N, 8, array dimension; number of weight rows loaded per job.
DATA_W, 64, row width (N bytes).
CNT_W, 7, width of the input-row count.
DRAIN_CYCLES, 24, drain timeout in enabled cycles after the last input row.

Ports:
clk  input  1  clock, rising edge
n_rst  input  1  asynchronous active-high reset (1 = reset asserted)
cmd_start  input  1  job request; sampled only in IDLE
cmd_num_inputs  input  CNT_W  input rows in this job
cmd_mode  input  2  activation mode for this job
cmd_bias  input  DATA_W  bias vector for this job
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a job completes (ok or error)
err  output  1  sticky error; cleared by the next accepted cmd_start
src_valid  input  1  source row valid
src_data  input  DATA_W  source row (weights first, then inputs)
src_ready  output  1  row consumed this cycle when src_valid && src_ready
dp_start_weights  output  1  datapath weight-load strobe
dp_start_array  output  1  datapath input-start strobe
dp_enable  output  1  datapath advance
dp_systolic_data  output  DATA_W  datapath row input
dp_bias_vec  output  DATA_W  latched cmd_bias
dp_activation_mode  output  2  latched cmd_mode
dp_activated  input  1  datapath result-row strobe
dp_activations  input  DATA_W  datapath result row
res_valid  output  1  result row valid
res_data  output  DATA_W  result row

Behaviour:
- Reset: state = IDLE. All outputs are 0: busy, done, err, src_ready, all dp_* outputs, res_valid, res_data. Counters are 0. Reset mid-job aborts immediately; no done pulse is issued.
- IDLE: src_ready = 0, dp_enable = 0.
  - On cmd_start: latch num_inputs, mode and bias (dp_bias_vec and dp_activation_mode hold these until the next accepted command); clear err.
  - Go to W_WAIT.
- W_WAIT: src_ready = 0. When src_valid = 1, go to W_LOAD next cycle.
- W_LOAD: exactly N cycles; weight counter w = 0..N-1.
  - src_ready = 1, dp_systolic_data = src_data, dp_enable = 1.
  - dp_start_weights = 1 only at w = 0.
  - If src_valid = 0 at any w: set err, pulse done, go to IDLE, drive dp_enable = 0 that cycle. This is required because datapath weight loading cannot pause.
  - After w = N-1: go to STREAM, or to FIN if num_inputs = 0.
- STREAM: input counter i.
  - src_ready = 1.
  - dp_enable = src_valid. dp_systolic_data = src_data when src_valid, else 0.
  - dp_start_array = 1 on the cycle the first input row (i = 0) is consumed.
  - Stalls (src_valid = 0) freeze the datapath; there is no timeout in STREAM.
  - After row num_inputs-1 is consumed: go to DRAIN.
- DRAIN:
  - src_ready = 0, dp_enable = 1, dp_systolic_data = 0, drain counter d increments each cycle.
  - Go to FIN when result count r = num_inputs.
  - If d reaches DRAIN_CYCLES first: set err, go to FIN.
- FIN: done = 1 for one cycle, dp_enable = 0; go to IDLE.
- Result path (registered, 1-cycle latency in every state except IDLE):
  - res_valid <= dp_activated, res_data <= dp_activations.
  - r increments on each dp_activated; r saturates at num_inputs.
  - In IDLE, res_valid = 0.
- Edge cases:
  - cmd_start while busy is ignored.
  - A cmd_start in the same cycle as FIN is ignored; it must be re-asserted in IDLE.
  - dp_activated in IDLE or W_* states is ignored and not counted.

Test Plan:
- Nominal job: cmd_start with num_inputs = 8, mode = 1, bias = 0x0101..01; src_valid always 1 -> dp_start_weights pulses at cycle 2 after cmd; 8 W_LOAD cycles; dp_start_array on the first input row; 8 res_valid pulses; done pulse; err = 0; busy falls after done.
- Source stalls: num_inputs = 4, src_valid low for 3 cycles between rows 1 and 2 -> dp_enable = 0 on exactly those 3 cycles; dp_systolic_data = 0 while stalled; 4 results; err = 0.
- Weight underrun: src_valid drops at w = 5 -> err = 1, single done pulse, return to IDLE, no dp_start_array.
- num_inputs = 0: 8 weight rows consumed, then done with no STREAM/DRAIN cycles; no res_valid.
- Drain timeout: dp_activated tied low, num_inputs = 2 -> err = 1 after 24 DRAIN cycles, then done.
- Reset mid-STREAM, and cmd_start while busy: n_rst = 1 at i = 3 -> all outputs 0 immediately, no done. cmd_start during W_LOAD -> ignored; the latched bias is unchanged.
